filtered_sample_fifo: RTL
=========================

Name: filtered_sample_fifo

Overview:
- Consumer end of the stereo Butterworth filter output handshake.
- Captures each filtered left/right sample pair on the filter's single-cycle ready pulse, optionally decimates, and stores pairs in a circular buffer.
- Downstream logic (pitch detector / bus slave) drains the buffer through a request/valid read port.
- Reports fill level, full, empty and a sticky overflow flag.

Parameters:
- DATA_SIZE, 24, sample width (signed two's complement), matches filter output width.
- DEPTH, 64, buffer depth in stereo pairs; must be a power of two, at least 2.
- DECIM, 1, keep one of every DECIM input pulses; range 1..255.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_left  input  DATA_SIZE  filtered left sample.
- in_right  input  DATA_SIZE  filtered right sample.
- in_valid  input  1  one-cycle pulse; samples valid in the same cycle (filter out_ready).
- rd_req  input  1  read request; honoured only if not empty.
- rd_left  output  DATA_SIZE  oldest left sample.
- rd_right  output  DATA_SIZE  oldest right sample.
- rd_valid  output  1  one-cycle pulse; rd_left/rd_right hold the popped pair.
- level  output  $clog2(DEPTH+1)  number of stored pairs.
- empty  output  1  level == 0.
- full  output  1  level == DEPTH.
- overflow  output  1  sticky; set when an accepted-by-decimator pair is dropped.
- clear_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async, active-high): all of the following take their reset values immediately.
  - Pointers, level and decimation counter = 0.
  - rd_left = rd_right = 0, rd_valid = 0.
  - empty = 1, full = 0, overflow = 0.
  - Buffer contents are don't-care.
- Decimator: counter dcnt runs 0..DECIM-1 and advances only on in_valid.
  - A pulse with dcnt == 0 is "taken"; dcnt wraps to 0 after DECIM-1.
  - DECIM = 1 means every pulse is taken.
- Write (wr_fire): a taken pulse is written iff (level < DEPTH) or rd_fire in the same cycle.
  - The pair is written at wr_ptr, and wr_ptr increments modulo DEPTH.
  - A taken pulse that cannot be written is dropped and sets overflow next cycle.
  - The decimation counter still advances on a dropped pulse.
- Read (rd_fire): rd_fire = rd_req && !empty, evaluated on the registered state at the start of the cycle.
  - On rd_fire: the next clock registers the pair at rd_ptr into rd_left/rd_right, asserts rd_valid for exactly one cycle, and rd_ptr increments modulo DEPTH.
  - Read latency is 1 cycle from rd_req to rd_valid.
  - rd_left/rd_right hold their value until the next rd_fire.
- rd_req while empty is ignored (no rd_valid). There is no fall-through: a write and a read request in the same cycle while empty writes only.
- Simultaneous rd_fire and wr_fire: level unchanged. A full buffer plus rd_req plus taken pulse accepts the write and stays full.
- level is a registered output: +1 on write only, -1 on read only. empty and full are decoded from the registered level.
- Overflow: a set event and clear_overflow in the same cycle leaves overflow = 1 (set wins).
- in_valid high for consecutive cycles: each high cycle counts as a separate pulse. This is legal, although the filter never does it.
- Arithmetic: pointers are $clog2(DEPTH) bits with natural wrap. Samples are stored unmodified with no sign manipulation.
- Storage: a single array of 2*DATA_SIZE-bit words, inferable as simple dual-port RAM with a registered read.

Decomposition:
- Shared audio package holds:
  - localparam AUDIO_DATA_SIZE = 24.
  - typedef stereo_sample_t: packed struct of signed left and right, each DATA_SIZE bits.
- One natural sub-module, sample_ram: DEPTH x 2*DATA_SIZE simple dual-port RAM with synchronous write and registered read.
- Decimator, pointers, level and flags stay in the top module.

Test Plan:
- Reset mid-operation: with 5 pairs stored, assert rst asynchronously between edges. Required: level = 0, empty = 1, overflow = 0 and rd_valid = 0 immediately. A subsequent rd_req yields no rd_valid.
- Basic order, DECIM = 1: write pairs (L,R) = (0x000001,0xFFFFFF), (0x7FFFFF,0x800000), (0x123456,0xEDCBA9). Read three times. Required: rd_valid one cycle after each rd_req, with the values in the same order and signs intact. Afterwards level = 0, empty = 1.
- Decimation, DECIM = 4: issue 10 in_valid pulses carrying L = 0..9. Required: level = 3, and reads return L = 0, 4, 8.
- Full and overflow, DEPTH = 4: write 6 pairs. Required: full = 1, level = 4, overflow = 1, and reads return the first 4 pairs. Then pulse clear_overflow: overflow = 0.
- Full with simultaneous read and write: from full, assert rd_req and a taken in_valid in the same cycle. Required: write accepted, level stays 4, overflow stays 0, and the oldest pair is returned.
- Empty boundary: from empty, assert rd_req and in_valid in the same cycle. Required: no rd_valid and level = 1. An rd_req on the next cycle returns that pair.

Source files
------------

// File: rtl/filtered_sample_fifo_pkg.sv
// ----------------------------------------------------------------------------
// filtered_sample_fifo_pkg
// Shared audio definitions for the filter-output capture path.
//   AUDIO_DATA_SIZE : sample width produced by the stereo Butterworth filter.
//   stereo_sample_t : one left/right pair, left in the upper half when packed.
// ----------------------------------------------------------------------------
package filtered_sample_fifo_pkg;

    localparam int AUDIO_DATA_SIZE = 24;

    typedef struct packed {
        logic signed [AUDIO_DATA_SIZE-1:0] left;
        logic signed [AUDIO_DATA_SIZE-1:0] right;
    } stereo_sample_t;

endpackage

// File: rtl/filtered_sample_fifo_sample_ram.sv
// ----------------------------------------------------------------------------
// filtered_sample_fifo_sample_ram
// Simple dual-port RAM, DEPTH words of WIDTH bits, synchronous write and
// registered read. The read register only updates when re is high, so rdata
// holds the last word read. A read and a write to the same address in one
// cycle return the old contents.
// Ports:
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   re    : read enable
//   raddr : read address
//   rdata : registered read data
// ----------------------------------------------------------------------------
module filtered_sample_fifo_sample_ram #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/filtered_sample_fifo.sv
// ----------------------------------------------------------------------------
// filtered_sample_fifo
// Captures filtered stereo pairs on the filter's one-cycle ready pulse,
// keeps one of every DECIM pulses, and buffers them in a circular RAM that
// downstream logic drains through a request/valid read port.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   in_left, in_right : filtered sample pair, valid with in_valid
//   in_valid          : one-cycle capture pulse
//   rd_req            : read request, ignored while empty
//   rd_left, rd_right : popped pair, held until the next pop
//   rd_valid          : one-cycle pulse, one cycle after an honoured rd_req
//   level             : stored pairs
//   empty, full       : decoded from level
//   overflow          : sticky drop flag, cleared by clear_overflow
//   clear_overflow    : synchronous clear of overflow (a drop wins)
// ----------------------------------------------------------------------------
module filtered_sample_fifo
    import filtered_sample_fifo_pkg::*;
#(
    parameter int DATA_SIZE = AUDIO_DATA_SIZE,
    parameter int DEPTH     = 64,
    parameter int DECIM     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_SIZE-1:0]         in_left,
    input  logic [DATA_SIZE-1:0]         in_right,
    input  logic                         in_valid,
    input  logic                         rd_req,
    output logic [DATA_SIZE-1:0]         rd_left,
    output logic [DATA_SIZE-1:0]         rd_right,
    output logic                         rd_valid,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    input  logic                         clear_overflow
);

    localparam int PW  = $clog2(DEPTH);
    localparam int LW  = $clog2(DEPTH+1);
    localparam int DCW = 8;

    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [DCW-1:0]         dcnt;
    logic                   have_data;
    logic [2*DATA_SIZE-1:0] ram_rdata;

    logic taken;
    logic rd_fire;
    logic wr_fire;
    logic drop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));

    assign taken   = in_valid && (dcnt == '0);
    assign rd_fire = rd_req && !empty;
    // A read in the same cycle frees the slot, so a full buffer still accepts.
    assign wr_fire = taken && ((level < LW'(DEPTH)) || rd_fire);
    assign drop    = taken && !wr_fire;

    filtered_sample_fifo_sample_ram #(
        .WIDTH (2*DATA_SIZE),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_sample_ram (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wr_ptr),
        .wdata ({in_left, in_right}),
        .re    (rd_fire),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // The RAM read register has no reset; have_data masks it to zero until
    // the first pop after reset. It only loads on a pop, so it also holds.
    assign rd_left  = have_data ? ram_rdata[2*DATA_SIZE-1:DATA_SIZE] : '0;
    assign rd_right = have_data ? ram_rdata[DATA_SIZE-1:0]           : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            dcnt      <= '0;
            rd_valid  <= 1'b0;
            have_data <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            rd_valid <= rd_fire;

            if (rd_fire) begin
                have_data <= 1'b1;
                rd_ptr    <= rd_ptr + PW'(1);
            end

            if (wr_fire) begin
                wr_ptr <= wr_ptr + PW'(1);
            end

            if (wr_fire && !rd_fire) begin
                level <= level + LW'(1);
            end else if (rd_fire && !wr_fire) begin
                level <= level - LW'(1);
            end

            if (in_valid) begin
                if (dcnt == DCW'(DECIM-1)) begin
                    dcnt <= '0;
                end else begin
                    dcnt <= dcnt + DCW'(1);
                end
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
